// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that frames one 16-bit channel sample
// at a time as a byte packet and feeds it to a start/busy byte transmitter.
// Packet: HDR, {5'b0,id}, sample[15:8], sample[7:0].
// Optional macro TXSCHED_CHECKSUM_EN appends id ^ msb ^ lsb as a fifth byte.
module uart_tx_sched #(
   parameter int          NCH = 4,
   parameter logic [7:0]  HDR = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    req_valid,
   input  logic [NCH*16-1:0] req_data,
   output logic [NCH-1:0]    req_ready,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              sched_busy,
   output logic [2:0]        grant_id
);

`ifdef TXSCHED_CHECKSUM_EN
   localparam logic [2:0] LAST_IDX = 3'd4;
`else
   localparam logic [2:0] LAST_IDX = 3'd3;
`endif

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;

   state_t      state_q, state_d;
   logic [2:0]  last_q, last_d;
   logic [2:0]  idx_q, idx_d;
   logic [2:0]  grant_q, grant_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [2:0]  id_q;
   logic [15:0] sample_q;

   logic [7:0]  valid_ext;
   logic [7:0]  ready_ext;
   logic [3:0]  cand;
   logic        win_found;
   logic [2:0]  win_idx;
   logic [15:0] win_sample;
   logic        accept;

`ifdef TXSCHED_CHECKSUM_EN
   function automatic logic [7:0] chk_byte(input logic [2:0] id, input logic [15:0] s);
      return {5'b0, id} ^ s[15:8] ^ s[7:0];
   endfunction
`endif

   // Byte at position idx of the packet built from a captured id/sample.
   function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [2:0] id,
                                           input logic [15:0] s);
      logic [7:0] b;
      case (idx)
         3'd0:    b = HDR;
         3'd1:    b = {5'b0, id};
         3'd2:    b = s[15:8];
         3'd3:    b = s[7:0];
`ifdef TXSCHED_CHECKSUM_EN
         3'd4:    b = chk_byte(id, s);
`endif
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Round-robin search starting after the last granted channel, wrapping at NCH.
   always_comb begin
      valid_ext            = '0;
      valid_ext[NCH-1:0]   = req_valid;
      win_found            = 1'b0;
      win_idx              = last_q;
      cand                 = '0;
      for (int k = 1; k <= NCH; k++) begin
         cand = {1'b0, last_q} + 4'(k);
         if (cand >= 4'(NCH)) cand = cand - 4'(NCH);
         if (!win_found && valid_ext[cand[2:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[2:0];
         end
      end
   end

   // Select the winning channel's sample and form the one-hot accept strobe.
   always_comb begin
      win_sample = '0;
      for (int i = 0; i < NCH; i++) begin
         if (win_idx == 3'(i)) win_sample = req_data[16*i +: 16];
      end
      ready_ext = '0;
      if (state_q == S_IDLE && win_found) ready_ext[win_idx] = 1'b1;
   end

   assign req_ready  = ready_ext[NCH-1:0];
   assign accept     = (state_q == S_IDLE) && win_found;
   assign tx_start   = (state_q == S_SEND);
   assign tx_data    = tx_data_q;
   assign sched_busy = (state_q != S_IDLE);
   assign grant_id   = grant_q;

   // Next-state logic: grant in IDLE, pulse start, then track the busy frame.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      idx_d     = idx_q;
      grant_d   = grant_q;
      tx_data_d = tx_data_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               last_d    = win_idx;
               grant_d   = win_idx;
               idx_d     = 3'd0;
               tx_data_d = HDR;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            state_d = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (tx_busy) state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (!tx_busy) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d     = idx_q + 3'd1;
                  tx_data_d = pkt_byte(idx_q + 3'd1, id_q, sample_q);
                  state_d   = S_SEND;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers with synchronous reset; reset abandons any packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_q    <= 3'(NCH - 1);
         idx_q     <= 3'd0;
         grant_q   <= 3'd0;
         tx_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         idx_q     <= idx_d;
         grant_q   <= grant_d;
         tx_data_q <= tx_data_d;
      end
   end

   // Packet payload captured once at acceptance so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         sample_q <= win_sample;
         id_q     <= win_idx;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a start/busy transmitter model.
// Honours TXSCHED_CHECKSUM_EN for the expected packet length and checksum byte.
module tb_uart_tx_sched;

`ifdef TXSCHED_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic        sched_busy;
   logic [2:0]  grant_id;

   int tests = 0;
   int fails = 0;

   int busy_len = 40;
   int bcnt = 0;

   logic [7:0] byteq[$];
   logic [3:0] readyq[$];
   int         barq[$];
   int  cyc = 0;
   int  last_hi = 0;
   logic prev_start = 1'b0;
   int  viol_busy = 0;
   int  viol_consec = 0;
   logic gap_en = 1'b0;
   int  win_starts = 0;
   int  gaps_meas = 0;
   int  gap_bad = 0;
   logic [7:0] e[5];

   uart_tx_sched #(.NCH(4), .HDR(8'hA5)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(tx_busy), .sched_busy(sched_busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy rises the cycle after start and lasts busy_len cycles.
   always @(posedge clk) begin
      if (tx_start && !tx_busy) begin
         tx_busy <= 1'b1;
         bcnt    <= busy_len - 1;
      end else if (tx_busy) begin
         if (bcnt == 0) tx_busy <= 1'b0;
         else bcnt <= bcnt - 1;
      end
   end

   // Mid-cycle monitor: records bytes, grants and start/busy protocol behaviour.
   always @(negedge clk) begin
      cyc++;
      if (|req_ready) begin
         readyq.push_back(req_ready);
         barq.push_back(byteq.size());
      end
      if (tx_start) begin
         byteq.push_back(tx_data);
         if (tx_busy) viol_busy++;
         if (prev_start) viol_consec++;
         if (gap_en) begin
            if (win_starts > 0) begin
               gaps_meas++;
               if (cyc - last_hi != 2) gap_bad++;
            end
            win_starts++;
         end
      end
      if (tx_busy) last_hi = cyc;
      prev_start = tx_start;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic clear_logs;
      byteq.delete();
      readyq.delete();
      barq.delete();
   endtask

   task automatic set_ch(input int ch, input logic [15:0] v);
      req_data[16*ch +: 16] = v;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      tick;
      while (sched_busy && n < 3000) begin tick; n++; end
      chk(tag, 32'(n < 3000), 32'd1);
   endtask

   task automatic wait_bytes(input int k, input string tag);
      int n = 0;
      while (byteq.size() < k && n < 3000) begin tick; n++; end
      chk(tag, 32'(n < 3000), 32'd1);
   endtask

   task automatic wait_ready(input int k, input string tag);
      int n = 0;
      while (readyq.size() < k && n < 3000) begin tick; n++; end
      chk(tag, 32'(n < 3000), 32'd1);
   endtask

   task automatic chk_bytes(input string tag, input int base);
      chk({tag, "_count"}, 32'(byteq.size()), 32'(base + NB));
      for (int i = 0; i < NB; i++) begin
         if (base + i < byteq.size())
            chk($sformatf("%s_b%0d", tag, i), 32'(byteq[base + i]), 32'(e[i]));
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_data = '0;
      repeat (3) tick;
      rst = 1'b0;

      // Reset state
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'h00);
      chk("rst_sched_busy", 32'(sched_busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);

      // Single request on ch2
      clear_logs();
      set_ch(2, 16'h1234);
      req_valid = 4'b0100;
      #1;
      chk("single_ready_comb", 32'(req_ready), 32'b0100);
      tick;
      req_valid = '0;
      chk("single_start", 32'(tx_start), 32'd1);
      chk("single_hdr_now", 32'(tx_data), 32'hA5);
      chk("single_grant", 32'(grant_id), 32'd2);
      chk("single_busy", 32'(sched_busy), 32'd1);
      chk("single_ready_off", 32'(req_ready), 32'd0);
      wait_idle("single_timeout");
      e = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h24};
      chk_bytes("single", 0);
      chk("single_ready_pulses", 32'(readyq.size()), 32'd1);
      chk("single_tx_data_hold", 32'(tx_data), 32'(e[NB-1]));

      // All four channels continuously valid
      do_reset();
      clear_logs();
      set_ch(0, 16'h0102); set_ch(1, 16'h1112); set_ch(2, 16'h2122); set_ch(3, 16'h3132);
      req_valid = 4'b1111;
      wait_ready(5, "rr_timeout");
      req_valid = '0;
      wait_idle("rr_idle_timeout");
      if (readyq.size() >= 5) begin
         chk("rr_g0", 32'(readyq[0]), 32'b0001);
         chk("rr_g1", 32'(readyq[1]), 32'b0010);
         chk("rr_g2", 32'(readyq[2]), 32'b0100);
         chk("rr_g3", 32'(readyq[3]), 32'b1000);
         chk("rr_g4", 32'(readyq[4]), 32'b0001);
         for (int i = 0; i < 5; i++)
            chk($sformatf("rr_bytes_before_g%0d", i), 32'(barq[i]), 32'(i * NB));
      end
      chk("rr_total_bytes", 32'(byteq.size()), 32'(5 * NB));
      chk("rr_last_grant", 32'(grant_id), 32'd0);

      // Rotation: ch3 joins after ch1 is granted
      do_reset();
      clear_logs();
      set_ch(1, 16'hC1C1); set_ch(3, 16'hC3C3);
      req_valid = 4'b0010;
      wait_ready(1, "rot_first_timeout");
      req_valid = 4'b1010;
      wait_ready(3, "rot_timeout");
      req_valid = '0;
      wait_idle("rot_idle_timeout");
      if (readyq.size() >= 3) begin
         chk("rot_g0", 32'(readyq[0]), 32'b0010);
         chk("rot_g1", 32'(readyq[1]), 32'b1000);
         chk("rot_g2", 32'(readyq[2]), 32'b0010);
      end
      if (byteq.size() > NB + 1) chk("rot_id2", 32'(byteq[NB + 1]), 32'h03);

      // Sample capture: data changes during byte 2
      do_reset();
      clear_logs();
      set_ch(0, 16'hAAAA);
      req_valid = 4'b0001;
      tick;
      req_valid = '0;
      wait_bytes(3, "cap_timeout");
      set_ch(0, 16'h5555);
      wait_idle("cap_idle_timeout");
      e = '{8'hA5, 8'h00, 8'hAA, 8'hAA, 8'h00};
      chk_bytes("cap", 0);

      // Reset during WAIT_LO of byte 1
      do_reset();
      clear_logs();
      set_ch(0, 16'h1357);
      req_valid = 4'b0001;
      tick;
      req_valid = '0;
      wait_bytes(2, "abort_timeout");
      repeat (5) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_tx_start", 32'(tx_start), 32'd0);
      chk("abort_idle", 32'(sched_busy), 32'd0);
      begin
         int n = 0;
         while (tx_busy && n < 200) begin tick; n++; end
         chk("abort_busy_timeout", 32'(n < 200), 32'd1);
      end
      clear_logs();
      set_ch(0, 16'h2468); set_ch(1, 16'h1111);
      req_valid = 4'b0011;
      #1;
      chk("abort_regrant_ch0", 32'(req_ready), 32'b0001);
      tick;
      req_valid = '0;
      wait_idle("abort_idle_timeout");
      e = '{8'hA5, 8'h00, 8'h24, 8'h68, 8'h4C};
      chk_bytes("abort", 0);

      // Stretched busy: protocol spacing
      busy_len = 100;
      clear_logs();
      win_starts = 0;
      gaps_meas = 0;
      gap_bad = 0;
      gap_en = 1'b1;
      set_ch(3, 16'hBEEF);
      req_valid = 4'b1000;
      tick;
      req_valid = '0;
      wait_idle("slow_timeout");
      gap_en = 1'b0;
      e = '{8'hA5, 8'h03, 8'hBE, 8'hEF, 8'h52};
      chk_bytes("slow", 0);
      chk("slow_starts", 32'(win_starts), 32'(NB));
      chk("slow_gaps", 32'(gaps_meas), 32'(NB - 1));
      chk("slow_gap_bad", 32'(gap_bad), 32'd0);

      chk("start_while_busy", 32'(viol_busy), 32'd0);
      chk("start_consecutive", 32'(viol_consec), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
